dmem_sram_ctrl: RTL and testbench
=================================

DMEM_SRAM_CTRL -- requirements
Module: dmem_sram_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, data and address width.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit storage words; power of two.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, range 0..15, extra cycles between request acceptance and response.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0; word-aligned.
REQ-005 i_clk  in  1  clock; one clock, all state on rising edge.
REQ-006 i_rst  in  1  reset; asynchronous, active-low.
REQ-007 i_DM_Addr  in  XLEN  word-aligned byte address; bits [1:0] ignored.
REQ-008 i_DM_Wd  in  XLEN  write data, already lane-shifted by requester.
REQ-009 i_DM_byte_en  in  4  per-byte write enable; bit n gates bits [8n+7:8n].
REQ-010 i_DM_Wen  in  1  write request.
REQ-011 i_DM_MemRead  in  1  read request.
REQ-012 o_DM_data_ready  out  1  one-cycle completion pulse.
REQ-013 o_DM_ReadData  out  XLEN  full word read; valid only with o_DM_data_ready.
REQ-014 o_DM_err  out  1  out-of-range access flag; valid only with o_DM_data_ready.

Function
REQ-015 FSM SHALL have states IDLE, WAIT, RESP.
REQ-016 In IDLE, request = i_DM_Wen | i_DM_MemRead; if high, latch address, write data, byte enables and operation at the clock edge.
REQ-017 With both i_DM_Wen and i_DM_MemRead high, operation SHALL be write; no read performed.
REQ-018 IDLE -> WAIT on request when WAIT_CYCLES > 0, loading a down-counter with WAIT_CYCLES; IDLE -> RESP on request when WAIT_CYCLES == 0.
REQ-019 WAIT: counter decrements every cycle; WAIT -> RESP in the cycle counter == 1; counter width max(1, clog2(WAIT_CYCLES+1)).
REQ-020 RESP: o_DM_data_ready = 1 for exactly that cycle; RESP -> IDLE unconditionally.
REQ-021 Latency: request sampled in IDLE at cycle 0 -> o_DM_data_ready in cycle WAIT_CYCLES+1.
REQ-022 Back-to-back: a request present in the first IDLE cycle after RESP SHALL be accepted in that cycle; no dead cycle beyond IDLE.
REQ-023 Inputs SHALL be ignored outside IDLE; deassertion or change of request mid-transaction SHALL NOT abort or alter it.
REQ-024 Word index = (latched addr - BASE_ADDR) >> 2; in range iff addr >= BASE_ADDR and index < DEPTH_WORDS.
REQ-025 Write, in range: at the clock edge ending RESP, update only bytes with byte_en set; byte_en 4'b0000 SHALL still complete handshake with no change.
REQ-026 Read, in range: o_DM_ReadData SHALL equal stored word at index during RESP; 0 in all other cycles.
REQ-027 Out of range: o_DM_err = 1 with o_DM_data_ready, no storage change, o_DM_ReadData = 0.
REQ-028 Read after write to same word SHALL return the written data; write commits before next transaction accepted.
REQ-029 o_DM_err SHALL be 0 whenever o_DM_data_ready is 0.

Reset
REQ-030 On i_rst low, asynchronously: state IDLE, counter 0, latched request cleared, o_DM_data_ready 0, o_DM_err 0, o_DM_ReadData 0.
REQ-031 Reset mid-transaction SHALL drop it: no response pulse, pending write not committed.
REQ-032 Storage contents SHALL NOT be reset; first accepted request no earlier than first rising edge after i_rst high.

Verification
REQ-033 WAIT_CYCLES=2: write 32'hDEAD_BEEF, byte_en 4'hF, addr 0x10 at cycle 0 -> data_ready in cycle 3 only; read 0x10 -> ReadData 32'hDEAD_BEEF, err 0.
REQ-034 Word 0x20 = 32'h1122_3344; write 32'h00AA_0000 byte_en 4'b0100 -> read returns 32'h11AA_3344.
REQ-035 DEPTH_WORDS=1024: read addr 0x1000 -> data_ready with err 1, ReadData 0; write 0x1000 then read 0x0 -> word 0 unchanged.
REQ-036 WAIT_CYCLES=0: write then read same address held continuously -> data_ready cycles 1 and 3, read returns new data.
REQ-037 Write 0x40 accepted, i_rst low during WAIT -> no data_ready, outputs 0; read 0x40 after reset -> pre-write value.
REQ-038 Wen and MemRead both high, addr 0x8, data 32'h5555_AAAA -> treated as write; ReadData 0 on response; subsequent read returns 32'h5555_AAAA.

Source files
------------

// File: rtl/dmem_sram_ctrl.sv
// Data-memory SRAM controller: accepts one word read or write from IDLE, waits
// WAIT_CYCLES, then presents a single-cycle response with read data or error.
module dmem_sram_ctrl #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH_WORDS = 1024,
  parameter int              WAIT_CYCLES = 2,
  parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_DM_Addr,
  input  logic [XLEN-1:0] i_DM_Wd,
  input  logic [3:0]      i_DM_byte_en,
  input  logic            i_DM_Wen,
  input  logic            i_DM_MemRead,
  output logic            o_DM_data_ready,
  output logic [XLEN-1:0] o_DM_ReadData,
  output logic            o_DM_err
);

  localparam int              IDX_W    = $clog2(DEPTH_WORDS);
  localparam int              CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0] DEPTH_L  = XLEN'(DEPTH_WORDS);
  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  logic [XLEN-1:0]  req_addr_q;
  logic [XLEN-1:0]  req_wd_q;
  logic [3:0]       req_be_q;
  logic             req_write_q;

  logic [XLEN-1:0]  addr_word;
  logic [XLEN-1:0]  addr_off;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             resp;
  logic             commit;

  // NOTE: storage is deliberately not reset; clearing a RAM array needs a
  // per-word write port or a reset sequencer, and contents must survive reset.
  logic [31:0]      mem [DEPTH_WORDS];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every combinational output is defaulted first so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_DM_Wen || i_DM_MemRead) begin
          accept = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request is captured once at acceptance; inputs are ignored afterwards.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      req_addr_q  <= '0;
      req_wd_q    <= '0;
      req_be_q    <= '0;
      req_write_q <= 1'b0;
    end else if (accept) begin
      req_addr_q  <= i_DM_Addr;
      req_wd_q    <= i_DM_Wd;
      req_be_q    <= i_DM_byte_en;
      req_write_q <= i_DM_Wen;
    end
  end

  always_comb begin
    addr_word = req_addr_q & ~LOW_MASK;
    addr_off  = addr_word - BASE_ADDR;
    in_range  = (addr_word >= BASE_ADDR) && ((addr_off >> 2) < DEPTH_L);
    idx       = addr_off[IDX_W+1:2];
  end

  assign resp   = (state_q == S_RESP);
  assign commit = resp && req_write_q && in_range;

  // Write commits on the edge that ends RESP, before the next request is taken.
  always_ff @(posedge i_clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (req_be_q[b]) begin
          mem[idx][8*b +: 8] <= req_wd_q[8*b +: 8];
        end
      end
    end
  end

  assign o_DM_data_ready = resp;
  assign o_DM_err        = resp && !in_range;
  assign o_DM_ReadData   = (resp && !req_write_q && in_range) ? XLEN'(mem[idx]) : '0;

endmodule

// File: tb/tb_dmem_sram_ctrl.sv
// Randomized scoreboard bench for dmem_sram_ctrl: a word-array reference model
// predicts each response; an independent monitor compares on every completion.
module tb_dmem_sram_ctrl;

  localparam int          W     = 2;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0, wd = '0;
  logic [3:0]  be = '0;
  logic        wen = 1'b0, mrd = 1'b0;
  logic        ready, err;
  logic [31:0] rdata;

  logic [31:0] addr0 = '0, wd0 = '0;
  logic [3:0]  be0 = '0;
  logic        wen0 = 1'b0, mrd0 = 1'b0;
  logic        ready0, err0;
  logic [31:0] rdata0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    bit          err;
    bit          chk_data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model[int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_sram_ctrl #(
    .XLEN(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W), .BASE_ADDR(BASE)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_DM_Addr(addr), .i_DM_Wd(wd),
    .i_DM_byte_en(be), .i_DM_Wen(wen), .i_DM_MemRead(mrd),
    .o_DM_data_ready(ready), .o_DM_ReadData(rdata), .o_DM_err(err)
  );

  dmem_sram_ctrl #(
    .XLEN(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(BASE)
  ) dut0 (
    .i_clk(clk), .i_rst(rst), .i_DM_Addr(addr0), .i_DM_Wd(wd0),
    .i_DM_byte_en(be0), .i_DM_Wen(wen0), .i_DM_MemRead(mrd0),
    .o_DM_data_ready(ready0), .o_DM_ReadData(rdata0), .o_DM_err(err0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit oor(input logic [31:0] a);
    longint aa = longint'(a & 32'hFFFF_FFFC);
    return (aa < longint'(BASE)) || (((aa - longint'(BASE)) / 4) >= DEPTH);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((longint'(a & 32'hFFFF_FFFC) - longint'(BASE)) / 4);
  endfunction

  task automatic model_write(input int i, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] cur;
    if (!model.exists(i)) begin
      if (b == 4'hF) model[i] = d;
    end else begin
      cur = model[i];
      for (int n = 0; n < 4; n++) if (b[n]) cur[8*n +: 8] = d[8*n +: 8];
      model[i] = cur;
    end
  endtask

  // Monitor: outputs must be quiet between completions; each completion pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (ready !== 1'b1) begin
      check("quiet_data", rdata, 32'h0);
      check("quiet_err", 32'(err), 32'h0);
    end else if (sb.size() == 0) begin
      check("spurious_ready", 32'(ready), 32'h0);
    end else begin
      e = sb.pop_front();
      check("resp_cycle", 32'(cyc), 32'(e.cyc));
      check("resp_err", 32'(err), 32'(e.err));
      if (e.chk_data) check("resp_data", rdata, e.data);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      wen = 1'b0; mrd = 1'b0; addr = '0; wd = '0; be = '0;
    end
  endtask

  // Issue one request; junk is driven while the DUT is busy to show it is ignored.
  task automatic issue(input bit w, input bit r, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    exp_t e;
    bit   bad;
    @(negedge clk);
    wen = w; mrd = r; addr = a; wd = d; be = b;
    bad        = oor(a);
    e.cyc      = cyc + W + 1;
    e.err      = bad;
    e.data     = '0;
    e.chk_data = 1'b1;
    if (w) begin
      if (!bad) model_write(word_of(a), d, b);
    end else if (!bad) begin
      if (model.exists(word_of(a))) e.data = model[word_of(a)];
      else e.chk_data = 1'b0;
    end
    sb.push_back(e);
    for (int i = 0; i < W + 1; i++) begin
      @(negedge clk);
      wen = 1'($urandom); mrd = 1'($urandom); addr = $urandom; wd = $urandom; be = 4'($urandom);
    end
  endtask

  task automatic rd(input logic [31:0] a);
    issue(1'b0, 1'b1, a, $urandom, 4'($urandom));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    issue(1'b1, 1'b0, a, d, b);
  endtask

  initial begin
    logic [31:0] a, d;
    bit          w, r;
    int          budget;

    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Known contents for words 0..31 and the last word.
    for (int i = 0; i < 32; i++) wr(32'(4 * i), $urandom, 4'hF);
    wr(32'h0000_0FFC, $urandom, 4'hF);

    wr(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    rd(32'h0000_0010);
    wr(32'h0000_0020, 32'h1122_3344, 4'hF);
    wr(32'h0000_0020, 32'h00AA_0000, 4'b0100);
    rd(32'h0000_0020);
    rd(32'h0000_1000);
    wr(32'h0000_1000, 32'hCAFE_F00D, 4'hF);
    rd(32'h0000_0000);
    issue(1'b1, 1'b1, 32'h0000_0008, 32'h5555_AAAA, 4'hF);
    rd(32'h0000_0008);
    wr(32'h0000_0024, 32'h0BAD_CAFE, 4'h0);
    rd(32'h0000_0024);
    rd(32'h0000_0FFE);
    idle(2);

    // Reset while a write to 0x40 is in WAIT: it must vanish without a pulse.
    @(negedge clk);
    wen = 1'b1; mrd = 1'b0; addr = 32'h0000_0040; wd = ~model[16]; be = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    wen = 1'b0; addr = '0; wd = '0; be = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    rd(32'h0000_0040);

    for (int t = 0; t < 80; t++) begin
      case ($urandom_range(0, 9))
        8:       a = 32'h0000_0FFC;
        9:       a = $urandom_range(0, 1) ? 32'h0000_1000 + 32'(4 * $urandom_range(0, 15)) : 32'hFFFF_FFFC;
        default: a = 32'(4 * $urandom_range(0, 31)) | 32'($urandom_range(0, 3));
      endcase
      d = $urandom;
      w = 1'($urandom);
      r = w ? 1'($urandom) : 1'b1;
      issue(w, r, a, d, 4'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(1);

    budget = 0;
    while (sb.size() != 0 && budget < 20) begin
      idle(1);
      budget++;
    end
    check("drain", 32'(sb.size()), 32'h0);

    // Zero-wait instance: write then read of the same address, back to back.
    d = 32'h6A5C_39E1;
    @(negedge clk);
    wen0 = 1'b1; mrd0 = 1'b0; addr0 = 32'h0000_0010; wd0 = d; be0 = 4'hF;
    check("w0_c0_ready", 32'(ready0), 32'h0);
    @(negedge clk);
    check("w0_c1_ready", 32'(ready0), 32'h1);
    check("w0_c1_err", 32'(err0), 32'h0);
    check("w0_c1_data", rdata0, 32'h0);
    wen0 = 1'b0; mrd0 = 1'b1;
    @(negedge clk);
    check("w0_c2_ready", 32'(ready0), 32'h0);
    @(negedge clk);
    check("w0_c3_ready", 32'(ready0), 32'h1);
    check("w0_c3_data", rdata0, d);
    check("w0_c3_err", 32'(err0), 32'h0);
    mrd0 = 1'b0; addr0 = '0; wd0 = '0; be0 = '0;
    @(negedge clk);
    check("w0_c4_ready", 32'(ready0), 32'h0);
    check("w0_c4_data", rdata0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
